// File: rtl/popcount_sequencer.sv
// ---------------------------------------------------------------------------
// popcount_sequencer
//
// Counts the set bits of a wide vector by time-multiplexing one CHUNK_SIZE-wide
// combinational adder tree. The tree is bit_vector_adder_recursion, defined
// below. The vector is captured on accept. One chunk is then summed per clock,
// LSB chunk first, and the total is presented with a valid/ready handshake.
//
// Parameters:
//   VECTOR_SIZE  input vector width (power of two, multiple of CHUNK_SIZE)
//   CHUNK_SIZE   bits summed per cycle (power of two, >= 2)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents in_vector
//   in_ready   block can accept a vector (IDLE only)
//   in_vector  vector to count, sampled only on the accepting edge
//   out_valid  out_sum holds a completed count
//   out_ready  consumer accepts out_sum
//   out_sum    set-bit count; shows the running accumulator outside DONE
//   busy       high in ACCUM or DONE
//
// Build option:
//   POPCOUNT_EARLY_EXIT_EN - if defined, ACCUM finishes as soon as no set bits
//   remain above the current chunk. out_sum is the same in both builds.
// ---------------------------------------------------------------------------

// Recursive adder tree: splits the vector in halves until single bits remain.
module bit_vector_adder_recursion #(
   parameter int unsigned VECTOR_SIZE = 16
) (
   input  logic [VECTOR_SIZE-1:0]      vector,
   output logic [$clog2(VECTOR_SIZE):0] count
);
   localparam int unsigned OUT_W = $clog2(VECTOR_SIZE) + 1;

   generate
      if (VECTOR_SIZE == 1) begin : g_leaf
         always_comb count = vector;
      end else begin : g_split
         localparam int unsigned HALF   = VECTOR_SIZE / 2;
         localparam int unsigned HALF_W = $clog2(HALF) + 1;

         logic [HALF_W-1:0] lo_count;
         logic [HALF_W-1:0] hi_count;

         bit_vector_adder_recursion #(.VECTOR_SIZE(HALF)) u_lo (
            .vector (vector[HALF-1:0]),
            .count  (lo_count)
         );

         bit_vector_adder_recursion #(.VECTOR_SIZE(HALF)) u_hi (
            .vector (vector[VECTOR_SIZE-1:HALF]),
            .count  (hi_count)
         );

         always_comb count = OUT_W'(lo_count) + OUT_W'(hi_count);
      end
   endgenerate
endmodule

module popcount_sequencer #(
   parameter int unsigned VECTOR_SIZE = 64,
   parameter int unsigned CHUNK_SIZE  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [VECTOR_SIZE-1:0]           in_vector,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [$clog2(VECTOR_SIZE):0]     out_sum,
   output logic                             busy
);
   localparam int unsigned NUM_CHUNKS = VECTOR_SIZE / CHUNK_SIZE;
   localparam int unsigned SUM_W      = $clog2(VECTOR_SIZE) + 1;
   localparam int unsigned CHUNK_W    = $clog2(CHUNK_SIZE) + 1;
   localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state;
   logic [VECTOR_SIZE-1:0] shreg;
   logic [SUM_W-1:0]       acc;
   logic [IDX_W-1:0]       idx;
   logic [CHUNK_W-1:0]     chunk_count;
   logic                   last_chunk;

   bit_vector_adder_recursion #(.VECTOR_SIZE(CHUNK_SIZE)) u_adder (
      .vector (shreg[CHUNK_SIZE-1:0]),
      .count  (chunk_count)
   );

`ifdef POPCOUNT_EARLY_EXIT_EN
   // The shift register zero-fills from the top, so "nothing above the current
   // chunk" means that every bit above chunk 0 is zero.
   logic upper_zero;
   generate
      if (NUM_CHUNKS > 1) begin : g_upper
         always_comb upper_zero = ~|shreg[VECTOR_SIZE-1:CHUNK_SIZE];
      end else begin : g_no_upper
         always_comb upper_zero = 1'b1;
      end
   endgenerate
   always_comb last_chunk = (idx == LAST_IDX) || upper_zero;
`else
   always_comb last_chunk = (idx == LAST_IDX);
`endif

   // out_sum mirrors the accumulator register. It is therefore stable during
   // DONE and shows the running total in the other states.
   always_comb out_sum = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         acc       <= '0;
         idx       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg    <= in_vector;
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc   <= acc + SUM_W'(chunk_count);
               shreg <= shreg >> CHUNK_SIZE;
               idx   <= idx + 1'b1;
               if (last_chunk) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_popcount_sequencer.sv
// ---------------------------------------------------------------------------
// tb_popcount_sequencer
//
// Self-checking bench for popcount_sequencer. It drives a default 64/16
// instance and a 16/16 single-chunk instance. Expected counts are
// pushed to a scoreboard queue at accept time and popped when out_valid rises.
// ---------------------------------------------------------------------------
module tb_popcount_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_vector;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_sum;
   logic        busy;

   logic        s_in_valid;
   logic        s_in_ready;
   logic [15:0] s_in_vector;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [4:0]  s_out_sum;
   logic        s_busy;

   int          errors = 0;
   int          checks = 0;
   int          sb[$];

   always #5 clk = ~clk;

   popcount_sequencer #(.VECTOR_SIZE(64), .CHUNK_SIZE(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vector (in_vector),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   popcount_sequencer #(.VECTOR_SIZE(16), .CHUNK_SIZE(16)) dut_single (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_vector (s_in_vector),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_sum   (s_out_sum),
      .busy      (s_busy)
   );

   function automatic int exp_latency(input logic [63:0] v);
`ifdef POPCOUNT_EARLY_EXIT_EN
      for (int c = 3; c >= 0; c--)
         if (v[c*16 +: 16] != 16'h0) return c + 1;
      return 1;
`else
      return 4;
`endif
   endfunction

   // Accept one vector; inputs change 1 time unit after an edge.
   task automatic accept(input logic [63:0] v);
      in_vector = v;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      sb.push_back($countones(v));
   endtask

   // Count edges after the accept until out_valid is seen (bounded).
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_vector = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_vector = '0; s_out_ready = 1'b1;
      #23;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 7'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b out_sum=%0d busy=%b, required 1 0 0 0",
                  in_ready, out_valid, out_sum, busy);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_count(input logic [63:0] v, input string name);
      int lat, got_exp;
      accept(v);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_accept: busy=%b in_ready=%b, required 1 0", name, busy, in_ready);
      end
      wait_out(lat);
      got_exp = sb.pop_front();
      checks++;
      if (lat !== exp_latency(v)) begin
         errors++;
         $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp_latency(v));
      end
      checks++;
      if (out_sum !== 7'(got_exp)) begin
         errors++;
         $display("FAIL %s_sum: got %0d, required %0d", name, out_sum, got_exp);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_return_idle: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                  name, out_valid, in_ready, busy);
      end
   endtask

   task automatic test_backpressure;
      int lat, e;
      out_ready = 1'b0;
      accept(64'h0000_00FF_0000_F00F);
      wait_out(lat);
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         in_vector = 64'hFFFF_FFFF_FFFF_FFFF;
         in_valid  = 1'b1;
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 7'(e) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold%0d: out_valid=%b out_sum=%0d in_ready=%b, required 1 %0d 0",
                     i, out_valid, out_sum, in_ready, e);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 7'(e)) begin
         errors++;
         $display("FAIL backpressure_final: out_valid=%b out_sum=%0d, required 1 %0d", out_valid, out_sum, e);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_no_extra: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                  out_valid, in_ready, busy);
      end
   endtask

   task automatic test_input_change;
      int lat, e;
      accept(64'h0F0F_0F0F_0F0F_0F0F);
      in_vector = 64'hFFFF_FFFF_FFFF_FFFF;
      in_valid  = 1'b1;
      wait_out(lat);
      in_valid  = 1'b0;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 7'(e) || e != 32) begin
         errors++;
         $display("FAIL input_change_sum: out_valid=%b got %0d, required 1 32", out_valid, out_sum);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort;
      accept(64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;           // now in 2nd ACCUM cycle
      rst_n = 1'b0;
      #1;
      void'(sb.pop_front());        // aborted result is never presented
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== 7'd0) begin
         errors++;
         $display("FAIL reset_abort: out_valid=%b in_ready=%b busy=%b out_sum=%0d, required 0 1 0 0",
                  out_valid, in_ready, busy, out_sum);
      end
      #4 rst_n = 1'b1;
      @(posedge clk); #1;
      test_count(64'h1, "after_abort");
   endtask

   task automatic test_back_to_back;
      int lat, e, ok_cnt;
      logic [63:0] v;
      for (int n = 0; n < 6; n++) begin
         v = {$urandom(), $urandom()};
         if (n == 0) v = 64'h0;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: in_ready=%b, required 1", n, in_ready);
         end
         accept(v);
         wait_out(lat);
         e = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 7'(e) || lat !== exp_latency(v)) begin
            errors++;
            $display("FAIL b2b_result%0d: out_valid=%b sum=%0d lat=%0d, required 1 %0d %0d",
                     n, out_valid, out_sum, lat, e, exp_latency(v));
         end
         @(posedge clk); #1;
      end
      ok_cnt = sb.size();
      checks++;
      if (ok_cnt !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", ok_cnt);
      end
   endtask

   task automatic test_single_chunk;
      int lat;
      s_in_vector = 16'hA5A5;
      s_in_valid  = 1'b1;
      @(posedge clk); #1;
      s_in_valid  = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 1 || s_out_sum !== 5'd8) begin
         errors++;
         $display("FAIL single_chunk: lat=%0d sum=%0d, required 1 8", lat, s_out_sum);
      end
      @(posedge clk); #1;
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_chunk_idle: out_valid=%b in_ready=%b, required 0 1", s_out_valid, s_in_ready);
      end
   endtask

   initial begin
      test_reset;
      test_count(64'hFFFF_FFFF_FFFF_FFFF, "all_ones");
      test_count(64'h8000_0000_0000_0001, "ends");
      test_count(64'h0000_0000_0000_0003, "low_only");
      test_backpressure;
      test_input_change;
      test_reset_abort;
      test_back_to_back;
      test_single_chunk;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/popcount_sequencer.md
Name: popcount_sequencer

Overview:
- Multi-cycle population-count controller for vectors wider than one adder tree should be.
- Time-multiplexes a single CHUNK_SIZE-wide combinational bit-vector adder (instance of bit_vector_adder_recursion, VECTOR_SIZE=CHUNK_SIZE) over a captured VECTOR_SIZE-bit input, accumulating one chunk per cycle.
- Valid/ready handshake on both input and output.
- Sits between a producer of wide flag/mask vectors and any consumer needing their set-bit count.

Parameters:
VECTOR_SIZE, 64, width of input vector; power of two, multiple of CHUNK_SIZE
CHUNK_SIZE, 16, width summed per cycle; power of two, >= 2
(derived) NUM_CHUNKS = VECTOR_SIZE/CHUNK_SIZE; SUM_W = $clog2(VECTOR_SIZE)+1

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents in_vector
in_ready  output  1  block can accept a vector
in_vector  input  VECTOR_SIZE  vector to count
out_valid  output  1  out_sum valid
out_ready  input  1  consumer accepts out_sum
out_sum  output  SUM_W  number of set bits in the accepted vector
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, out_valid=0, out_sum=0, busy=0; shift register, accumulator and chunk index cleared. Reset mid-operation aborts the count; the in-flight result is discarded and never presented.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load in_vector into shift register, acc=0, idx=0, go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each edge: acc <= acc + popcount(shreg[CHUNK_SIZE-1:0]) (zero-extended to SUM_W); shreg >>= CHUNK_SIZE; idx++.
  - Chunks are processed LSB chunk first.
  - At the edge processing chunk NUM_CHUNKS-1: go to DONE.
- DONE:
  - out_valid=1; out_sum=acc held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - in_ready=0 in DONE; no back-to-back accept in the same cycle.
- Latency: out_valid rises exactly NUM_CHUNKS rising edges after the accepting edge. Throughput is one vector per NUM_CHUNKS+2 cycles minimum, with out_ready held high.
- Width: acc is SUM_W bits; max value VECTOR_SIZE (all ones) fits without overflow; no wrap possible.
- in_valid in ACCUM/DONE is ignored; in_vector is sampled only at the accept edge. Later changes do not affect the result.
- out_ready while out_valid=0 is ignored.
- NUM_CHUNKS=1 is legal: one ACCUM cycle, then DONE.
- out_sum outside DONE shows the running accumulator; the consumer qualifies it with out_valid only.

Optional Feature:
POPCOUNT_EARLY_EXIT_EN:
- Defined: in ACCUM, if all bits of shreg above the current chunk are zero, the current edge adds the chunk and transitions to DONE regardless of idx.
  - Latency becomes (index of highest nonzero chunk)+1 edges.
  - An all-zero vector completes in 1 edge with out_sum=0.
- Undefined: fixed NUM_CHUNKS-edge latency for every vector.
- out_sum values are identical in both builds.

Test Plan:
- Defaults, in_vector=64'hFFFF_FFFF_FFFF_FFFF, out_ready=1 -> out_valid exactly 4 edges after accept, out_sum=64, returns to IDLE, in_ready=1 next cycle.
- in_vector=64'h8000_0000_0000_0001 -> out_sum=2. Latency 4 edges without the macro; 4 with POPCOUNT_EARLY_EXIT_EN (top chunk nonzero). in_vector=64'h0000_0000_0000_0003 -> out_sum=2, latency 1 edge with the macro.
- Output backpressure: out_ready=0 for 5 cycles after out_valid -> out_sum stable, in_ready=0, and in_valid pulses with other vectors are ignored. Raising out_ready completes the transfer with the original count.
- Input change: in_vector=64'h0F0F... accepted, then driven to all-ones during ACCUM -> out_sum=32.
- Reset abort: assert rst_n=0 during the 2nd ACCUM cycle -> out_valid=0, in_ready=1 immediately. Next vector 64'h1 after release -> out_sum=1, with no residue from the aborted count.
- Params VECTOR_SIZE=16, CHUNK_SIZE=16 -> in_vector=16'hA5A5 yields out_sum=8 after 1 edge.
